// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised 2-write/2-read register file with write bypass and busy scoreboard
module reg_file_mp #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [ADDR_W-1:0]          rs1,
  input  logic [ADDR_W-1:0]          rs2,
  output logic [DATA_W-1:0]          rdata1,
  output logic [DATA_W-1:0]          rdata2,
  input  logic                       claim,
  input  logic [ADDR_W-1:0]          claim_addr,
  output logic                       busy1,
  output logic                       busy2,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                w_ok0, w_ok1, w_okc;

  // an address is live when in range and not the hardwired zero register
  function automatic logic f_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
  endfunction

  // read value with port 1 taking precedence over port 0 when forwarding
  function automatic logic [DATA_W-1:0] f_rd(input logic [ADDR_W-1:0] a);
    if (!f_ok(a)) return '0;
    if (BYPASS != 0 && w_ok1 && waddr1 == a) return wdata1;
    if (BYPASS != 0 && w_ok0 && waddr0 == a) return wdata0;
    return r_mem[a];
  endfunction

  assign w_ok0  = we0 && f_ok(waddr0);
  assign w_ok1  = we1 && f_ok(waddr1);
  assign w_okc  = claim && f_ok(claim_addr);
  assign rdata1 = f_rd(rs1);
  assign rdata2 = f_rd(rs2);
  assign busy1  = f_ok(rs1) && r_busy[rs1];
  assign busy2  = f_ok(rs2) && r_busy[rs2];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = r_mem[g];
  end

  // storage and scoreboard: port 1 beats port 0, a claim beats a clearing write
  always_ff @(posedge clk)
    if (rst) begin
      r_mem  <= '{default: '0};
      r_busy <= '0;
    end else
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_ok1 && waddr1 == ADDR_W'(i)) r_mem[i] <= wdata1;
        else if (w_ok0 && waddr0 == ADDR_W'(i)) r_mem[i] <= wdata0;
        if (w_okc && claim_addr == ADDR_W'(i)) r_busy[i] <= 1'b1;
        else if ((w_ok1 && waddr1 == ADDR_W'(i)) || (w_ok0 && waddr0 == ADDR_W'(i))) r_busy[i] <= 1'b0;
      end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the mini-CPU datapath; the next generation of the 8x8 single-write file.
- Adds width/depth parameters, synchronous reset, and a second write port (e.g. load-return or multiplier result).
- Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard used by the issue stage for hazard detection.
- Sits between decode (read/claim) and writeback (writes); exposes a flat debug view of all registers.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 8, number of architectural registers (2..32, need not be a power of two).
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and claims.
- BYPASS, 1, when 1 reads forward same-cycle write data.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- we0  input  1  write enable, port 0.
- waddr0  input  ADDR_W  write address, port 0.
- wdata0  input  DATA_W  write data, port 0.
- we1  input  1  write enable, port 1 (higher priority).
- waddr1  input  ADDR_W  write address, port 1.
- wdata1  input  DATA_W  write data, port 1.
- rs1  input  ADDR_W  read address A.
- rs2  input  ADDR_W  read address B.
- rdata1  output  DATA_W  read data A (combinational).
- rdata2  output  DATA_W  read data B (combinational).
- claim  input  1  mark register claim_addr busy (instruction issued).
- claim_addr  input  ADDR_W  destination register being claimed.
- busy1  output  1  busy bit of rs1 (registered state).
- busy2  output  1  busy bit of rs2 (registered state).
- regs_flat  output  NUM_REGS*DATA_W  all registers; reg i at bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset: clk and rst as named above; reset is synchronous and active-high. On a rising edge with rst=1, all registers clear to 0 and all busy bits clear to 0. rst overrides any write or claim in that cycle.
- Outputs after reset: rdata1, rdata2 and regs_flat are 0, and busy1, busy2 are 0. With BYPASS=1, rdata still follows any same-cycle active write.
- Writes: on a rising edge with weN=1, reg[waddrN] <= wdataN. One-cycle latency to storage and regs_flat.
- Ignored writes: a write to address >= NUM_REGS is ignored. A write to register 0 is ignored when ZERO_REG=1.
- Write conflict: we0 and we1 both set to the same address -> port 1 data is stored and port 0 is discarded. Different addresses -> both are stored.
- Reads: rdataN = reg[rsN]. Returns 0 if rsN >= NUM_REGS, or if rsN = 0 with ZERO_REG=1.
- Bypass (BYPASS=1): if an active, non-ignored write targets rsN in the same cycle, rdataN = that write data. Port 1 wins over port 0. Only the data path is forwarded; regs_flat shows stored state only.
- No bypass (BYPASS=0): rdataN shows the old value until the edge.
- Scoreboard: busy[i] is a registered bit per register. A write to i clears busy[i] at the edge. claim=1 sets busy[claim_addr] at the edge.
- Claim and write to the same register in one cycle: busy ends 1 (new producer wins) and data is still written.
- Ignored claims: a claim to an out-of-range address is ignored. A claim to register 0 is ignored when ZERO_REG=1.
- busyN = busy[rsN], with no bypass of same-cycle clears or sets. busyN is 0 for out-of-range or hardwired-zero addresses.
- Reset mid-operation: outstanding busy bits and pending data are lost. Writes arriving in the cycle after rst deasserts behave normally.

Test Plan:
- Reset with defaults: write 0xAA to every register, pulse rst for 1 cycle -> regs_flat all zero; rdata1, rdata2, busy1, busy2 = 0.
- Write and read-back: we0, waddr0=3, wdata0=0x5C, then rs1=3 next cycle -> rdata1=0x5C. Write 0x11 to reg 0 -> rdata 0 (ZERO_REG=1).
- Port conflict and bypass: we0 and we1 both to reg 5 with 0x12/0x34, rs2=5 in the same cycle -> rdata2=0x34 combinationally; reg5=0x34 after the edge. Rerun with BYPASS=0 -> rdata2 shows the old value that cycle.
- Scoreboard: claim reg 4 -> busy1=1 (rs1=4) next cycle. Write reg 4 -> busy1=0 next cycle. Claim and write reg 4 in the same cycle -> busy stays 1 and reg4 is updated.
- Reset priority: rst=1 together with we1 to reg 2 and claim of reg 2 -> reg2=0 and busy=0 after the edge.
- Non-power-of-two depth (NUM_REGS=6, DATA_W=16, ADDR_W=3): write to address 7 is ignored; rs1=6 reads 0; claim address 7 sets no busy bit; 16-bit value 0xBEEF round-trips in reg 5.
